// File: rtl/lza_norm_arbiter_if.sv
// lza_norm_arbiter_if
//   Bundles the requester-side and result-side handshake signals of
//   lza_norm_arbiter.
//   req_valid/req_ready : per-requester handshake (NREQ bits each)
//   req_mant            : 16-bit mantissas, requester i at [16*i+15:16*i]
//   req_exp             : exponents, requester i at [EXP_W*i+EXP_W-1:EXP_W*i]
//   out_valid/out_ready : result handshake
//   out_mant/out_exp    : normalized mantissa, adjusted exponent
//   out_id/out_zero     : source requester index, zero-mantissa flag
//   The master modport is the environment side. The slave modport is the
//   arbiter side.
interface lza_norm_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int EXP_W = 8,
    parameter int ID_W  = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [16*NREQ-1:0]    req_mant;
    logic [EXP_W*NREQ-1:0] req_exp;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_mant;
    logic [EXP_W-1:0]      out_exp;
    logic [ID_W-1:0]       out_id;
    logic                  out_zero;

    modport master (
        output req_valid, req_mant, req_exp, out_ready,
        input  req_ready, out_valid, out_mant, out_exp, out_id, out_zero
    );

    modport slave (
        input  req_valid, req_mant, req_exp, out_ready,
        output req_ready, out_valid, out_mant, out_exp, out_id, out_zero
    );
endinterface

// File: rtl/lza_norm_arbiter.sv
// lza_norm_arbiter
//   Shares one 16-bit leading-zero detector and left shifter between NREQ
//   requesters. Each cycle a round-robin arbiter grants one requester. It
//   normalizes that requester's mantissa and lowers the exponent by the
//   shift amount. Two register stages sit between input and output:
//   S1 captures the request and S2 holds the result.
//   Ports:
//     clk       : clock; all state updates on the rising edge
//     rst       : asynchronous active-high reset
//     bus       : lza_norm_arbiter_if slave modport (requests and results)
//     stall_cnt : saturating count of cycles with out_valid & !out_ready.
//                 This port exists only when LZA_NORM_ARBITER_STATS_EN is
//                 defined.
//   Optional feature macro: LZA_NORM_ARBITER_STATS_EN
module lza_norm_arbiter #(
    parameter int NREQ  = 4,
    parameter int EXP_W = 8,
    parameter int ID_W  = 2
) (
    input logic              clk,
    input logic              rst,
    lza_norm_arbiter_if.slave bus
`ifdef LZA_NORM_ARBITER_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    // Width that can hold both the exponent and a leading-zero count of 0..16.
    localparam int CW = (EXP_W > 5) ? EXP_W : 5;

    logic                  s1_valid_q, s1_valid_d;
    logic [15:0]           s1_mant_q, s1_mant_d;
    logic [EXP_W-1:0]      s1_exp_q, s1_exp_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [15:0]           s2_mant_q, s2_mant_d;
    logic [EXP_W-1:0]      s2_exp_q, s2_exp_d;
    logic [ID_W-1:0]       s2_id_q, s2_id_d;
    logic                  s2_zero_q, s2_zero_d;

    logic                  s2_adv, s1_adv;
    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [NREQ-1:0]       ready_v;
    logic [4:0]            lz;
    logic [CW-1:0]         exp_x, lz_x;
    logic [15:0]           n_mant;
    logic [EXP_W-1:0]      n_exp;
    logic                  n_zero;

    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Round-robin search that starts at rr_ptr and wraps modulo NREQ.
    // NREQ need not be a power of two.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_v = '0;
        if (s1_adv && grant_found) ready_v[grant_idx] = 1'b1;
    end
    assign bus.req_ready = ready_v;

    // Leading-zero count. The scan runs upward, so the highest set bit is
    // the last one written and sets the count.
    always_comb begin
        lz = 5'd16;
        for (int unsigned b = 0; b < 16; b++) begin
            if (s1_mant_q[b]) lz = 5'(15 - b);
        end
    end

    always_comb begin
        exp_x  = CW'(s1_exp_q);
        lz_x   = CW'(lz);
        n_mant = '0;
        n_exp  = '0;
        n_zero = 1'b0;
        if (lz == 5'd16) begin
            n_zero = 1'b1;
        end else if (exp_x >= lz_x) begin
            n_mant = s1_mant_q << lz;
            n_exp  = EXP_W'(exp_x - lz_x);
        end else begin
            // Underflow: shift only as far as the exponent allows. The
            // result is left denormal.
            n_mant = s1_mant_q << s1_exp_q;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_exp_d   = s1_exp_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        s2_valid_d = s2_valid_q;
        s2_mant_d  = s2_mant_q;
        s2_exp_d   = s2_exp_q;
        s2_id_d    = s2_id_q;
        s2_zero_d  = s2_zero_q;

        if (s1_adv) begin
            s1_valid_d = grant_found;
            if (grant_found) begin
                s1_mant_d = bus.req_mant[16*grant_idx +: 16];
                s1_exp_d  = bus.req_exp[EXP_W*grant_idx +: EXP_W];
                s1_id_d   = grant_idx;
                rr_ptr_d  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mant_d = n_mant;
                s2_exp_d  = n_exp;
                s2_id_d   = s1_id_q;
                s2_zero_d = n_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_id_q    <= '0;
            rr_ptr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_id_q    <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_id_q    <= s1_id_d;
            rr_ptr_q   <= rr_ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_id_q    <= s2_id_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_mant  = s2_mant_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_id    = s2_id_q;
    assign bus.out_zero  = s2_zero_q;

`ifdef LZA_NORM_ARBITER_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s2_valid_q && !bus.out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_lza_norm_arbiter.sv
// tb_lza_norm_arbiter
//   Directed and random stimulus for lza_norm_arbiter. The reference model
//   treats the arbiter as a two-entry in-order buffer. Each result is
//   computed arithmetically from the granted request and becomes visible
//   on the cycle after it is captured.
module tb_lza_norm_arbiter;
    localparam int NREQ  = 4;
    localparam int EXP_W = 8;
    localparam int ID_W  = 2;
    localparam int RW    = 16 + EXP_W + ID_W + 1;

    typedef struct {
        int              cyc;
        logic [RW-1:0]   res;
    } item_t;

    logic clk;
    logic rst;
`ifdef LZA_NORM_ARBITER_STATS_EN
    logic [15:0] stall_cnt;
    int          stall_m;
`endif

    lza_norm_arbiter_if #(.NREQ(NREQ), .EXP_W(EXP_W), .ID_W(ID_W)) bus ();

    lza_norm_arbiter #(.NREQ(NREQ), .EXP_W(EXP_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LZA_NORM_ARBITER_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          rr        = 0;
    int          dut_hs    = 0;
    item_t       q[$];
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        logic [NREQ-1:0] sel;
        for (int k = 0; k < NREQ; k++) begin
            sel = NREQ'(1) << ((ptr + k) % NREQ);
            if ((v & sel) != '0) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] model_res(input int m, input int e, input int id);
        int lz, om, oe;
        if (m == 0) return {16'h0, EXP_W'(0), ID_W'(id), 1'b1};
        lz = 16 - $clog2(m + 1);
        if (e >= lz) begin
            om = (m << lz) & 32'hFFFF;
            oe = e - lz;
        end else begin
            om = (m << e) & 32'hFFFF;
            oe = 0;
        end
        return {16'(om), EXP_W'(oe), ID_W'(id), 1'b0};
    endfunction

    function automatic logic [RW-1:0] dut_out();
        return {bus.out_mant, bus.out_exp, bus.out_id, bus.out_zero};
    endfunction

    // One clock cycle. Apply inputs, check the DUT against the model, take
    // the clock edge, then advance the model.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] mv,
                         input logic [EXP_W*NREQ-1:0] ev, input logic rdy);
        bit    vis, accept;
        int    g;
        logic [NREQ-1:0] exp_ready;
        item_t it;
        bus.req_valid = v;
        bus.req_mant  = mv;
        bus.req_exp   = ev;
        bus.out_ready = rdy;
        #1;
        vis = (q.size() > 0) && (q[0].cyc < cyc);
        chk("out_valid", 32'(bus.out_valid), 32'(vis));
        if (vis) chk("out_data", 32'(dut_out()), 32'(q[0].res));
        accept    = (q.size() < 2) || rdy;
        g         = model_grant(v, rr);
        exp_ready = (accept && g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        last_ready = bus.req_ready;
        if ((bus.req_ready & v) != '0) dut_hs++;
`ifdef LZA_NORM_ARBITER_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
        @(posedge clk);
        cyc++;
        if (vis && rdy) void'(q.pop_front());
        if (accept && g >= 0) begin
            it.cyc = cyc;
            it.res = model_res(int'(mv[16*g +: 16]), int'(ev[EXP_W*g +: EXP_W]), g);
            q.push_back(it);
            rr = (g + 1) % NREQ;
        end
`ifdef LZA_NORM_ARBITER_STATS_EN
        if (vis && !rdy && stall_m != 32'hFFFF) stall_m++;
`endif
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outputs", 32'({bus.out_valid, dut_out()}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        rr = 0;
`ifdef LZA_NORM_ARBITER_STATS_EN
        stall_m = 0;
`endif
    endtask

    initial begin
        logic [16*NREQ-1:0]    mv;
        logic [EXP_W*NREQ-1:0] ev;
        logic [RW-1:0]         held;
        int                    hs0;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_mant  = '0;
        bus.req_exp   = '0;
        bus.out_ready = 1'b0;
        mv = '0;
        ev = '0;
`ifdef LZA_NORM_ARBITER_STATS_EN
        stall_m = 0;
`endif
        do_reset();
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'h0);

        // Single request from requester 2.
        mv[32 +: 16] = 16'h00F0;
        ev[16 +: 8]  = 8'd20;
        cycle(4'b0100, mv, ev, 1'b1);
        cycle(4'b0000, mv, ev, 1'b1);
        chk("single_valid", 32'(bus.out_valid), 32'h1);
        chk("single_mant", 32'(bus.out_mant), 32'hF000);
        chk("single_exp", 32'(bus.out_exp), 32'd12);
        chk("single_id", 32'(bus.out_id), 32'd2);
        chk("single_zero", 32'(bus.out_zero), 32'd0);
        cycle(4'b0000, mv, ev, 1'b1);

        // Zero mantissa on requester 0, then underflow on requester 1.
        mv = '0;
        ev = '0;
        ev[0 +: 8]   = 8'd5;
        mv[16 +: 16] = 16'h0001;
        ev[8 +: 8]   = 8'd3;
        cycle(4'b0001, mv, ev, 1'b1);
        cycle(4'b0010, mv, ev, 1'b1);
        chk("zero_res", 32'({bus.out_mant, bus.out_exp, bus.out_zero}), 32'h1);
        cycle(4'b0000, mv, ev, 1'b1);
        chk("uflow_mant", 32'(bus.out_mant), 32'h0008);
        chk("uflow_exp", 32'(bus.out_exp), 32'd0);
        cycle(4'b0000, mv, ev, 1'b1);

        // Round robin with all requesters valid and no backpressure.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NREQ; i++) mv[16*i +: 16] = 16'($urandom);
            cycle((k < 8) ? 4'b1111 : 4'b0000, mv, ev, 1'b1);
            if (k >= 1 && k <= 8) begin
                chk("rr_valid", 32'(bus.out_valid), 32'h1);
                chk("rr_id", 32'(bus.out_id), 32'((k - 1) % 4));
            end
        end

        // Backpressure: only two results may be in flight.
        hs0 = dut_hs;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0011, mv, ev, 1'b0);
            if (k == 1) held = dut_out();
        end
        chk("bp_handshakes", 32'(dut_hs - hs0), 32'd2);
        chk("bp_ready", 32'(bus.req_ready), 32'h0);
        chk("bp_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_hold", 32'(dut_out()), 32'(held));
        for (int k = 0; k < 3; k++) cycle(4'b0000, mv, ev, 1'b1);

        // Refill both stages, then reset asynchronously between clock edges.
        cycle(4'b0011, mv, ev, 1'b0);
        cycle(4'b0011, mv, ev, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        do_reset();
        cycle(4'b1010, mv, ev, 1'b1);
        chk("rst_first_grant", 32'(last_ready), 32'b0010);
        cycle(4'b0000, mv, ev, 1'b1);
        cycle(4'b0000, mv, ev, 1'b1);

`ifdef LZA_NORM_ARBITER_STATS_EN
        do_reset();
        cycle(4'b0001, mv, ev, 1'b0);
        cycle(4'b0000, mv, ev, 1'b0);
        for (int k = 0; k < 7; k++) cycle(4'b0000, mv, ev, 1'b0);
        chk("stall7", 32'(stall_cnt), 32'd7);
        cycle(4'b0000, mv, ev, 1'b1);
`endif

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                mv[16*i +: 16]       = 16'($urandom >> $urandom_range(16, 32));
                ev[EXP_W*i +: EXP_W] = EXP_W'(($urandom_range(0, 1) == 1) ?
                                              $urandom_range(0, 20) : $urandom_range(0, 255));
            end
            cycle(NREQ'($urandom_range(0, 15)), mv, ev, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 4; k++) cycle(4'b0000, mv, ev, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
